// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// to program memory, and holds the core in reset until the requested count lands.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [15:0]           num_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  core_reset_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // One extra bit so the full 16-bit request compares against the depth without truncation.
  localparam logic [16:0] DEPTH_LIMIT = 17'(MEMORY_DEPTH);

  state_t                state_q;
  logic [15:0]           count_q;
  logic [15:0]           word_idx_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           asm_q;
  logic                  ready_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  core_reset_q;
  logic                  done_q;
  logic                  error_q;

  logic count_bad;
  assign count_bad = (num_words_i == 16'd0) || ({1'b0, num_words_i} > DEPTH_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            done_q       <= 1'b0;
            core_reset_q <= 1'b1;
            if (count_bad) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q    <= S_LOAD;
              error_q    <= 1'b0;
              ready_q    <= 1'b1;
              count_q    <= num_words_i;
              word_idx_q <= 16'd0;
              byte_cnt_q <= 2'd0;
            end
          end
        end

        S_LOAD: begin
          if (byte_valid_i) begin
            if (byte_cnt_q == 2'd3) begin
              // Last byte goes straight into the write data; the partial word never reaches the port.
              wdata_q    <= DATA_WIDTH'({byte_i, asm_q});
              addr_q     <= DATA_WIDTH'({word_idx_q, 2'b00});
              we_q       <= 1'b1;
              ready_q    <= 1'b0;
              byte_cnt_q <= 2'd0;
              state_q    <= S_WRITE;
            end else begin
              unique case (byte_cnt_q)
                2'd0:    asm_q[7:0]   <= byte_i;
                2'd1:    asm_q[15:8]  <= byte_i;
                default: asm_q[23:16] <= byte_i;
              endcase
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        S_WRITE: begin
          if (word_idx_q == count_q - 16'd1) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            core_reset_q <= 1'b0;
          end else begin
            word_idx_q <= word_idx_q + 16'd1;
            state_q    <= S_LOAD;
            ready_q    <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign core_reset_o = core_reset_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes, a
// negedge monitor pops and compares every mem_we_o pulse.
module tb_program_loader;

  localparam int MEMORY_DEPTH = 32;
  localparam int DATA_WIDTH   = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start_i;
  logic [15:0]           num_words_i;
  logic                  byte_valid_i;
  logic [7:0]            byte_i;
  logic                  byte_ready_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  core_reset_o;
  logic                  done_o;
  logic                  error_o;

  program_loader #(.MEMORY_DEPTH(MEMORY_DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .num_words_i(num_words_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .core_reset_o(core_reset_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_we_cyc = -1;
  logic prev_we = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      last_we_cyc = cyc;
      check("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr_o, mem_wdata_o);
      end else begin
        check("write_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
        check("write_data", 64'(mem_wdata_o), 64'(exp_data_q.pop_front()));
      end
    end
    prev_we = (mem_we_o === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [7:0] bq[$]);
    for (int i = 0; i < bq.size() / 4; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_data_q.push_back({bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]});
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start_i     = 1'b1;
    num_words_i = n;
    tick();
    start_i     = 1'b0;
    num_words_i = 16'($urandom);
  endtask

  // gap: 0 = valid held high, 1 = idle cycle after each byte, 2 = random idle cycles
  task automatic send_bytes(input logic [7:0] bq[$], input int gap);
    for (int i = 0; i < bq.size(); i++) begin
      int   budget = 0;
      logic acc    = 1'b0;
      byte_valid_i = 1'b1;
      byte_i       = bq[i];
      while (!acc) begin
        acc = byte_ready_o;
        tick();
        budget++;
        if (budget > 200) begin
          n_cmp++;
          n_err++;
          $display("FAIL byte_accept_timeout: byte %0d never accepted", i);
          byte_valid_i = 1'b0;
          return;
        end
      end
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        byte_valid_i = 1'b0;
        byte_i       = 8'($urandom);
        tick();
      end
    end
    byte_valid_i = 1'b0;
    byte_i       = 8'($urandom);
  endtask

  task automatic wait_done(output int done_cyc);
    int budget = 0;
    done_cyc = -1;
    while (done_o !== 1'b1) begin
      tick();
      budget++;
      if (budget > 400) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: done_o never rose");
        return;
      end
    end
    done_cyc = cyc;
  endtask

  task automatic random_bytes(input int n, output logic [7:0] bq[$]);
    bq = {};
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] bq[$];
    int c0;
    int dc;
    logic [15:0] bad_counts[3];

    reset        = 1'b1;
    start_i      = 1'b0;
    num_words_i  = 16'd0;
    byte_valid_i = 1'b0;
    byte_i       = 8'd0;
    do_reset();
    repeat (3) tick();
    check("rst_core_reset", 64'(core_reset_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_ready", 64'(byte_ready_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_wdata", 64'(mem_wdata_o), 64'd0);

    // Two-word program, valid held high
    bq = {8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    push_expected(bq);
    do_start(16'd2);
    c0 = cyc;
    check("ready_after_start", 64'(byte_ready_o), 64'd1);
    send_bytes(bq, 0);
    wait_done(dc);
    check("load2_total_cycles", 64'(dc - c0), 64'd10);
    check("done_after_last_write", 64'(dc), 64'(last_we_cyc + 1));
    check("done_core_reset", 64'(core_reset_o), 64'd0);

    // Illegal counts: zero, one past depth, and one that truncates to a legal value
    bad_counts[0] = 16'd0;
    bad_counts[1] = 16'(MEMORY_DEPTH + 1);
    bad_counts[2] = 16'h8001;
    foreach (bad_counts[k]) begin
      do_start(bad_counts[k]);
      check("error_set", 64'(error_o), 64'd1);
      check("error_core_reset", 64'(core_reset_o), 64'd1);
      check("error_ready", 64'(byte_ready_o), 64'd0);
      byte_valid_i = 1'b1;
      repeat (6) begin
        byte_i = 8'($urandom);
        tick();
      end
      byte_valid_i = 1'b0;
      check("error_held", 64'(error_o), 64'd1);
    end
    random_bytes(4, bq);
    push_expected(bq);
    do_start(16'd1);
    check("error_cleared", 64'(error_o), 64'd0);
    check("error_to_load", 64'(byte_ready_o), 64'd1);
    send_bytes(bq, 0);
    wait_done(dc);

    // Gapped stream
    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_expected(bq);
    do_start(16'd1);
    send_bytes(bq, 1);
    wait_done(dc);

    // Reset in the middle of a word
    do_start(16'd1);
    bq = {8'h55, 8'h66};
    send_bytes(bq, 0);
    do_reset();
    check("midrst_core_reset", 64'(core_reset_o), 64'd1);
    check("midrst_ready", 64'(byte_ready_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    bq = {8'h01, 8'h02, 8'h03, 8'h04};
    push_expected(bq);
    do_start(16'd1);
    send_bytes(bq, 0);
    wait_done(dc);

    // Full-depth load, then restart from DONE
    random_bytes(4 * MEMORY_DEPTH, bq);
    push_expected(bq);
    do_start(16'(MEMORY_DEPTH));
    send_bytes(bq, 2);
    wait_done(dc);
    check("full_last_addr", 64'(mem_addr_o), 64'h7C);
    check("full_done_core_reset", 64'(core_reset_o), 64'd0);
    random_bytes(4, bq);
    push_expected(bq);
    do_start(16'd1);
    check("restart_core_reset", 64'(core_reset_o), 64'd1);
    check("restart_done_drop", 64'(done_o), 64'd0);
    send_bytes(bq, 0);
    wait_done(dc);

    // Randomized loads
    repeat (6) begin
      int n = $urandom_range(1, 8);
      random_bytes(4 * n, bq);
      push_expected(bq);
      do_start(16'(n));
      send_bytes(bq, $urandom_range(0, 2));
      wait_done(dc);
    end

    repeat (3) tick();
    check("pending_writes", 64'(exp_addr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time controller that fills the instruction memory from a byte stream before the single-cycle core runs. It accepts bytes over a valid/ready handshake, packs each group of four into a little-endian 32-bit instruction, and issues one write per word to the program memory write port. It holds the core in reset until the programmed word count has been written. It sits between the host/UART receiver and the program memory, and drives the core's reset.

## Interface

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in program memory; maximum legal load length.
- DATA_WIDTH, 32, instruction/address width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request a load; sampled only in IDLE, DONE, ERROR.
- num_words_i  input  16  words to load; latched on accepted start_i.
- byte_valid_i  input  1  byte_i holds a valid byte.
- byte_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_we_o  output  1  program memory write enable, one cycle per word.
- mem_addr_o  output  DATA_WIDTH  byte address of the write, word-aligned (word_index<<2, bits [1:0]=0).
- mem_wdata_o  output  DATA_WIDTH  assembled instruction.
- core_reset_o  output  1  active-high reset to the core.
- done_o  output  1  load completed successfully.
- error_o  output  1  illegal word count requested.

## Operation

- States: IDLE, LOAD, WRITE, DONE, ERROR. On reset the state is IDLE.
- Outputs are decoded from registered state/datapath only; no combinational path from inputs to outputs.
- Accepted start in IDLE/DONE/ERROR: start_i=1 in IDLE, DONE or ERROR.
  - If num_words_i==0 or num_words_i>MEMORY_DEPTH, go to ERROR.
  - Otherwise latch the count, clear word_index and byte_cnt, and go to LOAD.
- LOAD:
  - byte_ready_o=1.
  - A byte is accepted when byte_valid_i&byte_ready_o. Byte k (k=0..3) goes into mem_wdata_o[8k+7:8k] (little-endian), and byte_cnt increments.
  - Acceptance of byte 3 sets byte_cnt to 0 and goes to WRITE.
  - start_i is ignored in LOAD and WRITE.
- WRITE (exactly one cycle):
  - byte_ready_o=0, mem_we_o=1, mem_addr_o=word_index<<2, mem_wdata_o stable.
  - Next state: if word_index==count-1, go to DONE; else increment word_index and go to LOAD.
- DONE: core_reset_o=0, done_o=1. A valid start_i re-enters LOAD, and core_reset_o reasserts in the same cycle done_o drops.
- ERROR: error_o=1, core_reset_o=1. It stays in ERROR until a valid start_i (to LOAD) or reset. An invalid start_i remains in ERROR.
- core_reset_o=1 in every state except DONE.
- Count arithmetic:
  - word_index and byte_cnt are unsigned and never wrap within a load, because the count is bounded by MEMORY_DEPTH.
  - The compare uses the full 16-bit num_words_i.
- mem_wdata_o and mem_addr_o hold their last values outside WRITE. mem_we_o=0 outside WRITE.
- Reset mid-load: all registers return to reset values. A partial word is discarded and no write is issued.

## Timing

- Reset values:
  - state=IDLE, byte_cnt=0, word_index=0.
  - byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - core_reset_o=1, done_o=0, error_o=0.
- start_i sampled at edge E:
  - A valid count gives byte_ready_o=1 from cycle E+1.
  - An invalid count gives error_o=1 from cycle E+1.
- Fourth byte accepted at edge N: mem_we_o=1 during cycle N+1 only. byte_ready_o is low in that cycle and returns high in cycle N+2 unless the load is finished.
- Throughput is one word per 5 cycles with byte_valid_i held high.
- Last WRITE cycle at W: done_o=1 and core_reset_o=0 from cycle W+1.
- byte_valid_i is ignored when byte_ready_o=0. byte_i may change freely when byte_valid_i=0.

## Test plan

- Reset, then idle 3 cycles:
  - Required: core_reset_o=1, done_o=0, error_o=0, mem_we_o=0, byte_ready_o=0.
- start_i with num_words_i=2, stream bytes 13 05 00 00 93 05 10 00 with valid held high:
  - First write: mem_addr_o=0x0, mem_wdata_o=0x00000513.
  - Second write: mem_addr_o=0x4, mem_wdata_o=0x00100593.
  - Each write lasts exactly one cycle.
  - done_o=1 and core_reset_o=0 the cycle after the second write.
  - Total 10 cycles from first ready.
- start_i with num_words_i=0, then with num_words_i=33 (MEMORY_DEPTH=32):
  - Required: error_o=1 and no mem_we_o pulse in either case.
  - A following start_i with num_words_i=1 clears error_o and enters LOAD.
- Gapped stream (byte_valid_i toggling every other cycle), num_words_i=1, bytes AA BB CC DD:
  - Required: a single write with mem_wdata_o=0xDDCCBBAA. Bytes offered while byte_ready_o=0 are not consumed.
- reset asserted after 2 of 4 bytes, then a new start_i with num_words_i=1 and bytes 01 02 03 04:
  - Required: no write before the reset, and the write after it is 0x04030201 at address 0.
- Full-depth load of 32 words, then start_i again from DONE:
  - The last write address is 0x7C.
  - On the restart, core_reset_o reasserts one cycle after start_i and done_o drops.
